// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: mode encodings and the default reset PC.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        MODE_SEQ  = 3'd0,
        MODE_BR   = 3'd1,
        MODE_J    = 3'd2,
        MODE_JAL  = 3'd3,
        MODE_JR   = 3'd4,
        MODE_JALR = 3'd5
    } mode_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = $clog2(RAS_DEPTH),
    parameter int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic              full;
    logic              empty;

    assign full  = (count == CNT_W'(RAS_DEPTH));
    assign empty = (count == '0);
    // ptr is the next write slot, so the newest entry sits one below it
    assign top   = empty ? '0 : mem[ptr - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, PC register and RAS-based return checking.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          JIMM_W    = 26,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic              br_taken,
    input  logic [JIMM_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_miss,
    output logic              ras_ovf,
    output logic              misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       br_off32;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] next_pc;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  ras_count;

    assign pc_plus4    = pc + ADDR_W'(4);
    assign link        = pc_plus4;
    assign br_off32    = {{14{imm[15]}}, imm[15:0], 2'b00};
    assign br_target   = pc_plus4 + br_off32[ADDR_W-1:0];
    // region bits come from pc+4 so a jump in the last slot lands in the next region
    assign jump_target = {pc_plus4[ADDR_W-1:JIMM_W+2], imm, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        push    = 1'b0;
        pop     = 1'b0;
        case (mode)
            MODE_BR:   next_pc = br_taken ? br_target : pc_plus4;
            MODE_J:    next_pc = jump_target;
            MODE_JAL: begin
                next_pc = jump_target;
                push    = en;
            end
            MODE_JR: begin
                next_pc = rs_val;
                pop     = en;
            end
            MODE_JALR: begin
                next_pc = rs_val;
                push    = en;
            end
            default:   next_pc = pc_plus4;
        endcase
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (link),
        .top       (ras_top),
        .count     (ras_count),
        .ovf       (ras_ovf)
    );

    assign ras_empty = (ras_count == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= RESET_PC[ADDR_W-1:0];
            ras_miss <= 1'b0;
            misalign <= 1'b0;
        end else begin
            ras_miss <= pop && (ras_empty || (ras_top != rs_val));
            if (en) begin
                pc <= next_pc;
                if (next_pc[1:0] != 2'b00) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, jumps, RAS push/pop/overflow, stalls, reset.
module tb_pc_sequencer;

    localparam int ADDR_W = 32;
    localparam int JIMM_W = 26;

    localparam logic [2:0] M_SEQ  = 3'd0;
    localparam logic [2:0] M_BR   = 3'd1;
    localparam logic [2:0] M_JAL  = 3'd3;
    localparam logic [2:0] M_JR   = 3'd4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic [2:0]        mode;
    logic              br_taken;
    logic [JIMM_W-1:0] imm;
    logic [ADDR_W-1:0] rs_val;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_miss;
    logic              ras_ovf;
    logic              misalign;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] exp_rs;

    pc_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mode      (mode),
        .br_taken  (br_taken),
        .imm       (imm),
        .rs_val    (rs_val),
        .pc        (pc),
        .link      (link),
        .ras_top   (ras_top),
        .ras_empty (ras_empty),
        .ras_miss  (ras_miss),
        .ras_ovf   (ras_ovf),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs, let one rising edge sample them, then settle past the edge.
    task automatic step(input logic e, input logic [2:0] m, input logic bt,
                        input logic [JIMM_W-1:0] im, input logic [ADDR_W-1:0] rs);
        en       = e;
        mode     = m;
        br_taken = bt;
        imm      = im;
        rs_val   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, M_SEQ, 1'b0, '0, '0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; mode = M_SEQ; br_taken = 1'b0; imm = '0; rs_val = '0;
        #2;
        do_reset();
        check("reset_pc", pc, 32'h3000);
        check("reset_link", link, 32'h3004);
        check("reset_empty", {31'd0, ras_empty}, 1);
        check("reset_top", ras_top, 0);
        check("reset_flags", {29'd0, ras_miss, ras_ovf, misalign}, 0);

        // Sequential flow
        step(1'b1, M_SEQ, 1'b0, '0, '0); check("seq1", pc, 32'h3004);
        step(1'b1, M_SEQ, 1'b0, '0, '0); check("seq2", pc, 32'h3008);
        step(1'b1, M_SEQ, 1'b0, '0, '0); check("seq3", pc, 32'h300C);
        step(1'b1, M_SEQ, 1'b0, '0, '0); check("seq4", pc, 32'h3010);

        // Backward branch taken: 0x3014 - 16
        step(1'b1, M_BR, 1'b1, 26'h000FFFC, '0); check("br_taken", pc, 32'h3004);
        step(1'b1, M_SEQ, 1'b0, '0, '0);
        step(1'b1, M_SEQ, 1'b0, '0, '0);
        step(1'b1, M_SEQ, 1'b0, '0, '0); check("seq_back", pc, 32'h3010);
        step(1'b1, M_BR, 1'b0, 26'h000FFFC, '0); check("br_not_taken", pc, 32'h3014);

        // JAL then matching JR
        do_reset();
        check("rst2_pc", pc, 32'h3000);
        step(1'b1, M_JAL, 1'b0, 26'h0000C10, '0);
        check("jal_pc", pc, 32'h3040);
        check("jal_top", ras_top, 32'h3004);
        check("jal_not_empty", {31'd0, ras_empty}, 0);
        step(1'b1, M_JR, 1'b0, '0, 32'h3004);
        check("jr_pc", pc, 32'h3004);
        check("jr_no_miss", {31'd0, ras_miss}, 0);
        check("jr_empty", {31'd0, ras_empty}, 1);

        // Misaligned JR target on empty stack
        step(1'b1, M_JR, 1'b0, '0, 32'h3006);
        check("mis_pc", pc, 32'h3006);
        check("mis_flag", {31'd0, misalign}, 1);
        check("mis_empty_miss", {31'd0, ras_miss}, 1);
        step(1'b1, M_SEQ, 1'b0, '0, '0);
        check("mis_seq_pc", pc, 32'h300A);
        check("miss_one_cycle", {31'd0, ras_miss}, 0);
        check("mis_sticky", {31'd0, misalign}, 1);

        // Stall holds pc and RAS, suppresses miss
        step(1'b1, M_JAL, 1'b0, 26'h0000100, '0);
        check("jal2_pc", pc, 32'h0400);
        check("jal2_top", ras_top, 32'h300E);
        step(1'b0, M_JAL, 1'b0, 26'h0000200, '0);
        step(1'b0, M_JR, 1'b0, '0, 32'h0);
        check("stall_pc", pc, 32'h0400);
        check("stall_top", ras_top, 32'h300E);
        check("stall_no_miss", {31'd0, ras_miss}, 0);
        step(1'b1, M_JR, 1'b0, '0, 32'h300E);
        check("jr2_pc", pc, 32'h300E);
        check("jr2_no_miss", {31'd0, ras_miss}, 0);
        check("jr2_empty", {31'd0, ras_empty}, 1);

        // Address wrap is silent
        step(1'b1, M_JR, 1'b0, '0, 32'hFFFF_FFFC);
        step(1'b1, M_SEQ, 1'b0, '0, '0);
        check("wrap_pc", pc, 32'h0);

        // Overflow: nine JALs with imm=i+1 keep the newest eight links
        do_reset();
        check("rst3_flags", {29'd0, ras_miss, ras_ovf, misalign}, 0);
        exp_pc = 32'h3000;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exp_pc + 32'd4);
            if (exp_q.size() > 8) void'(exp_q.pop_front());
            exp_pc = 32'(i + 1) * 32'd4;
            step(1'b1, M_JAL, 1'b0, JIMM_W'(i + 1), '0);
            check("ovf_jal_pc", pc, exp_pc);
            check("ovf_jal_top", ras_top, exp_q[$]);
            check("ovf_flag", {31'd0, ras_ovf}, (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            exp_rs = exp_q.pop_back();
            step(1'b1, M_JR, 1'b0, '0, exp_rs);
            check("pop_pc", pc, exp_rs);
            check("pop_no_miss", {31'd0, ras_miss}, 0);
            check("pop_top", ras_top, (exp_q.size() == 0) ? 32'd0 : exp_q[$]);
        end
        check("pop_all_empty", {31'd0, ras_empty}, 1);
        step(1'b1, M_JR, 1'b0, '0, 32'h3004);
        check("pop9_pc", pc, 32'h3004);
        check("pop9_miss", {31'd0, ras_miss}, 1);
        check("ovf_sticky", {31'd0, ras_ovf}, 1);

        // Reset during a JAL clears everything
        step(1'b1, M_JR, 1'b0, '0, 32'h3002);
        step(1'b1, M_JAL, 1'b0, 26'h0000040, '0);
        check("pre_rst_flags", {30'd0, ras_ovf, misalign}, 32'h3);
        reset_n = 1'b0;
        step(1'b1, M_JAL, 1'b0, 26'h0000040, '0);
        reset_n = 1'b1;
        check("rst_jal_pc", pc, 32'h3000);
        check("rst_jal_empty", {31'd0, ras_empty}, 1);
        check("rst_jal_top", ras_top, 0);
        check("rst_jal_flags", {29'd0, ras_miss, ras_ovf, misalign}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, 32, PC/address width in bits; legal values 16..32.
REQ-002 Parameter JIMM_W, 26, jump-immediate width; region bits = ADDR_W-JIMM_W-2, which SHALL be ≥1.
REQ-003 Parameter RESET_PC, 32'h0000_3000, PC value loaded by reset, truncated to ADDR_W.
REQ-004 Parameter RAS_DEPTH, 8, return-address-stack entries; power of two, 2..32.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 en  in  1  advance enable; 0 = stall, all state holds.
REQ-008 mode  in  3  0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 JALR; 6-7 treated as SEQ.
REQ-009 br_taken  in  1  branch condition, meaningful only in BR.
REQ-010 imm  in  JIMM_W  jump immediate (J/JAL); low 16 bits are the branch offset (BR).
REQ-011 rs_val  in  ADDR_W  register target (JR/JALR).
REQ-012 pc  out  ADDR_W  current PC (registered).
REQ-013 link  out  ADDR_W  pc+4, combinational; write-back value for JAL/JALR.
REQ-014 ras_top  out  ADDR_W  current RAS top entry (0 when empty).
REQ-015 ras_empty  out  1  RAS holds no entries.
REQ-016 ras_miss  out  1  one-cycle pulse: JR popped an entry ≠ rs_val, or popped an empty stack.
REQ-017 ras_ovf  out  1  sticky: a push occurred while the stack was full.
REQ-018 misalign  out  1  sticky: a loaded next-PC had bits [1:0] ≠ 0.

Function
REQ-019 Next PC when en=1: SEQ pc+4; BR taken pc+4+(sext(imm[15:0])<<2), not taken pc+4; J/JAL {(pc+4)[ADDR_W-1:JIMM_W+2], imm, 2'b00}; JR/JALR rs_val.
REQ-020 All adds SHALL be modulo 2^ADDR_W; wrap past the top address is silent.
REQ-021 pc SHALL update exactly one cycle after en=1 is sampled (latency 1); en=0 holds pc and the RAS and suppresses ras_miss.
REQ-022 JAL and JALR SHALL push link onto the RAS; JR SHALL pop; J, BR and SEQ leave the RAS unchanged.
REQ-023 Push when full: overwrite oldest entry (circular), count saturates at RAS_DEPTH, ras_ovf set.
REQ-024 Pop when empty: count stays 0, ras_miss pulses, pc still loads rs_val.
REQ-025 ras_miss is registered, asserted the cycle after the JR is accepted, for one cycle.
REQ-026 The RAS never affects the architectural target; rs_val is always used for JR/JALR.
REQ-027 misalign SHALL set when the next-PC loaded has nonzero [1:0]; pc still loads that value unmodified.
REQ-028 ras_ovf and misalign clear only on reset.

Reset
REQ-029 reset_n=0 at a rising edge: pc=RESET_PC, RAS count=0, pointer=0, ras_miss=0, ras_ovf=0, misalign=0; reset overrides en and mode.
REQ-030 Reset mid-operation discards all RAS contents; entries need not be cleared, but ras_top SHALL read 0 while empty.

Structure
REQ-031 Shared package holds the mode encodings (SEQ..JALR) and the default RESET_PC constant.
REQ-032 One sub-module, ras_stack (parametrised ADDR_W, RAS_DEPTH: push/pop/top/count/ovf); next-PC selection and pc register stay in pc_sequencer.

Verification
REQ-033 Reset then hold en=1, mode=SEQ for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C.
REQ-034 pc=0x3010, BR, br_taken=1, imm[15:0]=0xFFFC -> pc=0x3004; same with br_taken=0 -> 0x3014.
REQ-035 pc=0x3000, JAL, imm=0x0000C10 -> pc=0x0000_3040, link=0x3004 pushed, ras_top=0x3004; then JR rs_val=0x3004 -> pc=0x3004, ras_miss=0, ras_empty=1.
REQ-036 RAS_DEPTH=8: 9 consecutive JALs -> ras_ovf=1, 8 entries kept; 9 JRs -> ninth yields ras_miss pulse.
REQ-037 JR rs_val=0x3006 -> pc=0x3006, misalign=1 sticky; en=0 for 2 cycles mid-sequence -> pc and ras_top unchanged.
REQ-038 reset_n=0 asserted during a JAL cycle -> pc=0x3000, ras_empty=1, flags 0 next cycle.
